// File: rtl/magnitude_compare_serial_if.sv
// -----------------------------------------------------------------------------
// magnitude_compare_serial_if
//
// Purpose:
//   Bundles the operand-side and result-side handshakes of the serial
//   magnitude comparator so the engine and its user share one typed bundle.
//
// Parameters:
//   WIDTH  operand width in bits (>= 2)
//   DIGIT  bits compared per clock (WIDTH must be a multiple of DIGIT)
//
// Signals:
//   in_valid   operand pair valid                 (master -> slave)
//   in_ready   engine can accept, IDLE only       (slave  -> master)
//   in_a       operand A                          (master -> slave)
//   in_b       operand B                          (master -> slave)
//   in_signed  1 = two's-complement compare       (master -> slave)
//   out_valid  result valid, held until accepted  (slave  -> master)
//   out_ready  consumer accepts result            (master -> slave)
//   out_gt     A > B                              (slave  -> master)
//   out_eq     A == B                             (slave  -> master)
//   out_lt     A < B                              (slave  -> master)
//   out_cycles digits examined for this result    (slave  -> master)
//   busy       engine is not idle                 (slave  -> master)
//
// Modports:
//   master  the block feeding operands and consuming results
//   slave   the compare engine
// -----------------------------------------------------------------------------
interface magnitude_compare_serial_if #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = $clog2(K) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic             out_gt;
  logic             out_eq;
  logic             out_lt;
  logic [CW-1:0]    out_cycles;
  logic             busy;

  // The user side drives operands and result acceptance.
  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_signed,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_gt,
    input  out_eq,
    input  out_lt,
    input  out_cycles,
    input  busy
  );

  // The engine side drives readiness, the result and status.
  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_signed,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_gt,
    output out_eq,
    output out_lt,
    output out_cycles,
    output busy
  );

endinterface

// File: rtl/magnitude_compare_serial.sv
// -----------------------------------------------------------------------------
// magnitude_compare_serial
//
// Purpose:
//   Serial magnitude comparator. Accepts one WIDTH-bit operand pair at a time,
//   scans it MSB-first DIGIT bits per clock and reports exactly one of
//   greater-than / equal / less-than together with the number of digits that
//   were examined. Handles unsigned and two's-complement operands.
//
// Parameters:
//   WIDTH  operand width in bits (>= 2)
//   DIGIT  bits compared per clock; WIDTH must be a multiple of DIGIT
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    magnitude_compare_serial_if.slave handshake bundle:
//            in_valid/in_ready/in_a/in_b/in_signed  operand side
//            out_valid/out_ready/out_gt/out_eq/out_lt/out_cycles  result side
//            busy  engine not idle
//
// Build option:
//   CMP_EARLY_EXIT_EN  when defined, the scan stops at the first differing
//                      digit, so latency and out_cycles depend on the data.
//                      When undefined, every compare scans all K digits and
//                      reports out_cycles = K (constant-time operation).
//                      The gt/eq/lt result is the same either way.
// -----------------------------------------------------------------------------
module magnitude_compare_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  magnitude_compare_serial_if.slave      bus
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = $clog2(K) + 1;
  // idx needs at least one bit even when the whole word is a single digit.
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);
  localparam logic [CW-1:0] K_CYCLES = CW'(K);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aSh_q;
  logic [WIDTH-1:0] bSh_q;
  logic [IW-1:0]    idx_q;
  logic             gt_q;
  logic             eq_q;
  logic             lt_q;
  logic             outValid_q;
  logic [CW-1:0]    cycles_q;

  logic [WIDTH-1:0] aSh_d;
  logic [WIDTH-1:0] bSh_d;
  logic [IW-1:0]    idx_d;
  logic [CW-1:0]    cyclesHere_d;
  logic [DIGIT-1:0] topA;
  logic [DIGIT-1:0] topB;
  logic             digitsDiffer;
  logic             aGreater;
  logic             lastDigit;
  logic             decided;

  // Capture values for a new operand pair. Flipping the sign bit of both
  // operands maps two's-complement order onto unsigned order, so the scan
  // itself never has to know about signedness.
  logic [WIDTH-1:0] aLoad;
  logic [WIDTH-1:0] bLoad;

  always_comb begin
    aLoad = {bus.in_a[WIDTH-1] ^ bus.in_signed, bus.in_a[WIDTH-2:0]};
    bLoad = {bus.in_b[WIDTH-1] ^ bus.in_signed, bus.in_b[WIDTH-2:0]};
  end

  // Per-digit datapath: look at the top digit of each shift register,
  // decide whether they differ and which is larger, and prepare the
  // shifted registers, the next digit index and the digit count that
  // would be reported if the scan stopped at this digit.
  always_comb begin
    topA         = aSh_q[WIDTH-1 -: DIGIT];
    topB         = bSh_q[WIDTH-1 -: DIGIT];
    digitsDiffer = (topA != topB);
    aGreater     = (topA > topB);
    lastDigit    = (idx_q == LAST_IDX);
    decided      = gt_q | lt_q;
    aSh_d        = aSh_q << DIGIT;
    bSh_d        = bSh_q << DIGIT;
    idx_d        = idx_q + IW'(1);
    cyclesHere_d = CW'(idx_q) + CW'(1);
  end

  // Control FSM with registered result outputs.
  // IDLE waits for an operand pair, SCAN walks the digits MSB-first and
  // DONE holds the result until the consumer takes it. Only the first
  // differing digit sets gt/lt; once one of them is set, later digits
  // are still shifted through (in the constant-time build) but never
  // touch the flags again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      aSh_q      <= '0;
      bSh_q      <= '0;
      idx_q      <= '0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
      outValid_q <= 1'b0;
      cycles_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            aSh_q    <= aLoad;
            bSh_q    <= bLoad;
            idx_q    <= '0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            cycles_q <= '0;
            state_q  <= SCAN;
          end
        end

        SCAN: begin
          if (digitsDiffer && !decided) begin
            gt_q <= aGreater;
            lt_q <= ~aGreater;
          end
`ifdef CMP_EARLY_EXIT_EN
          if (digitsDiffer) begin
            cycles_q   <= cyclesHere_d;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            aSh_q <= aSh_d;
            bSh_q <= bSh_d;
            idx_q <= idx_d;
            if (lastDigit) begin
              eq_q       <= 1'b1;
              cycles_q   <= K_CYCLES;
              outValid_q <= 1'b1;
              state_q    <= DONE;
            end
          end
`else
          aSh_q <= aSh_d;
          bSh_q <= bSh_d;
          idx_q <= idx_d;
          if (lastDigit) begin
            eq_q       <= ~decided & ~digitsDiffer;
            cycles_q   <= K_CYCLES;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
`endif
        end

        DONE: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end

        default: begin
          outValid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // Every output is either a register or a decode of the state register,
  // so nothing on the input side reaches the outputs combinationally.
  always_comb begin
    bus.in_ready   = (state_q == IDLE);
    bus.busy       = (state_q != IDLE);
    bus.out_valid  = outValid_q;
    bus.out_gt     = gt_q;
    bus.out_eq     = eq_q;
    bus.out_lt     = lt_q;
    bus.out_cycles = cycles_q;
  end

endmodule

// File: tb/tb_magnitude_compare_serial.sv
// -----------------------------------------------------------------------------
// tb_magnitude_compare_serial
//
// Purpose:
//   Directed self-checking bench for magnitude_compare_serial with WIDTH=8,
//   DIGIT=2 (K=4). Expected flags, latency and digit counts are hand-computed
//   per vector; the early-exit build (CMP_EARLY_EXIT_EN) selects the
//   data-dependent latency column.
// -----------------------------------------------------------------------------
module tb_magnitude_compare_serial;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int K     = WIDTH / DIGIT;
  localparam int MAX_WAIT = 20;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  magnitude_compare_serial_if #(.WIDTH(WIDTH), .DIGIT(DIGIT)) bus ();

  magnitude_compare_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
    end
  endtask

  // Runs one complete compare: offer the pair, count edges until the result
  // appears, check the flags and digit count, then accept the result.
  // Inputs change on the falling edge; outputs are sampled 1 ns after the
  // rising edge. expEarly* apply to the early-exit build, the constant-time
  // build always expects K edges and K digits.
  task automatic applyStimulus(input string tag, input logic [7:0] a,
                               input logic [7:0] b, input logic sgn,
                               input logic expGt, input logic expEq,
                               input logic expLt, input int expEarlyLat,
                               input int expEarlyCyc);
    int lat;
    int expLat;
    int expCyc;
`ifdef CMP_EARLY_EXIT_EN
    expLat = expEarlyLat;
    expCyc = expEarlyCyc;
`else
    expLat = K;
    expCyc = K;
`endif
    @(negedge clk);
    checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = sgn;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_gt"}, 32'(bus.out_gt), 32'(expGt));
    checkOutput({tag, "_eq"}, 32'(bus.out_eq), 32'(expEq));
    checkOutput({tag, "_lt"}, 32'(bus.out_lt), 32'(expLt));
    checkOutput({tag, "_cycles"}, 32'(bus.out_cycles), 32'(expCyc));
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_valid_cleared"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_ready_again"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    total          = 0;
    bad            = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_signed  = 1'b0;
    bus.out_ready  = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_flags", 32'({bus.out_gt, bus.out_eq, bus.out_lt}), 32'd0);
    checkOutput("rst_cycles", 32'(bus.out_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: tag, a, b, signed, gt, eq, lt, early latency, early cycles.
    applyStimulus("u80_7f", 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
    applyStimulus("eq5a",   8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 4, 4);
    applyStimulus("s80_01", 8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1);
    applyStimulus("u80_01", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
    applyStimulus("u12_13", 8'h12, 8'h13, 1'b0, 1'b0, 1'b0, 1'b1, 4, 4);
    applyStimulus("sff_fe", 8'hFF, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0, 4, 4);
    applyStimulus("s7f_80", 8'h7F, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1);
    applyStimulus("u7f_80", 8'h7F, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
    applyStimulus("u1c_1d", 8'h1C, 8'h1D, 1'b0, 1'b0, 1'b0, 1'b1, 4, 4);

    // Backpressure: result held while new operands are offered and ignored.
    @(negedge clk);
    bus.in_a      = 8'h12;
    bus.in_b      = 8'h13;
    bus.in_signed = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("bp_latency", 32'(lat), 32'(K));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_a      = 8'hF0;
      bus.in_b      = 8'h0F;
      bus.in_valid  = (i % 2) == 0;
      @(posedge clk);
      #1;
      checkOutput("bp_valid_held", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_flags_held", 32'({bus.out_gt, bus.out_eq, bus.out_lt}), 32'b001);
      checkOutput("bp_cycles_held", 32'(bus.out_cycles), 32'(K));
      checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("bp_release_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("bp_release_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_no_ghost_op", 32'({bus.busy, bus.out_valid}), 32'd0);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    bus.in_a      = 8'hFF;
    bus.in_b      = 8'h00;
    bus.in_signed = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("mid_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("arst_flags", 32'({bus.out_gt, bus.out_eq, bus.out_lt}), 32'd0);
    checkOutput("arst_cycles", 32'(bus.out_cycles), 32'd0);
    checkOutput("arst_busy", 32'(bus.busy), 32'd0);
    checkOutput("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus("post_rst_eq03", 8'h03, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 4, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
